dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width; covers the 65536-word data RAM.
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request; bit 0 is the core load/store port, bit 1 is the loader/debug port.
REQ-006 req_ready  output  2  per-requester accept; a transfer on bit i occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-007 req_we  input  2  per-requester write flag, qualified by req_valid.
REQ-008 req_addr0, req_addr1  input  ADDR_W each  word address per requester.
REQ-009 req_wdata0, req_wdata1  input  DATA_W each  write data per requester.
REQ-010 rsp_valid  output  2  one-cycle response pulse to the owning requester; there is no response backpressure.
REQ-011 rsp_rdata  output  DATA_W  read data (pre-write old word for writes), shared by both requesters and qualified by rsp_valid.
REQ-012 mem_en, mem_we  output  1 each  RAM enable and write strobe.
REQ-013 mem_addr  output  32  RAM address, equal to the registered ADDR_W address zero-extended.
REQ-014 mem_di  output  DATA_W  RAM write data.
REQ-015 mem_dout  input  DATA_W  RAM read-first registered output, valid the cycle after mem_en.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-017 In IDLE and RESP, req_ready SHALL be one-hot on the granted requester whenever any req_valid is high, and zero otherwise; in ISSUE, req_ready SHALL be 0.
REQ-018 On acceptance, we/addr/wdata and the owner index SHALL be registered and the FSM SHALL enter ISSUE.
REQ-019 In ISSUE, mem_en SHALL be 1, mem_we SHALL equal the registered we, and mem_addr/mem_di SHALL be driven from the registers; the next state SHALL be RESP.
REQ-020 In RESP, rsp_valid[owner] SHALL be 1 and rsp_rdata SHALL equal mem_dout; the next state SHALL be ISSUE if a new request is accepted in the same cycle, otherwise IDLE.
REQ-021 Outside ISSUE, mem_en and mem_we SHALL be 0.
REQ-022 Latency: a request accepted in cycle N SHALL see mem_en in cycle N+1 and rsp_valid in cycle N+2.
REQ-023 Peak throughput SHALL be one transaction every 2 cycles, back to back.
REQ-024 Writes SHALL also return rsp_valid; rsp_rdata on a write SHALL be the old word at that address.
REQ-025 When both requesters are valid in the same cycle, exactly one SHALL be granted; the losing requester SHALL hold its request stable.
REQ-026 req_valid changing while ISSUE is active SHALL have no effect on the in-flight transaction.

Reset
REQ-027 While rstn is low, the FSM SHALL be in IDLE and req_ready, rsp_valid, mem_en and mem_we SHALL be 0.
REQ-028 While rstn is low, rsp_rdata, mem_addr and mem_di SHALL be 0, and the round-robin pointer SHALL select requester 0.
REQ-029 Reset asserted mid-transaction SHALL drop that transaction, and no rsp_valid SHALL follow after release.
REQ-030 The first grant after reset SHALL be possible in the first clock edge with rstn high.

Configuration
REQ-031 With macro DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer moves past the last granted requester, so two continuously valid requesters alternate.
REQ-032 With DMEM_ARB_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 winning, and no pointer register SHALL exist.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the state enum, the registered command struct (we, addr, wdata, owner), the NREQ=2 constant and the port index constants.
REQ-034 Grant logic SHALL be one sub-module, dmem_arb_grant (valid vector and pointer in, one-hot grant out).

Verification
REQ-035 Read: after RAM[5]=0xDEADBEEF, requester 0 reads addr 5 at cycle N -> mem_en in N+1 and rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF in N+2.
REQ-036 Write then read: requester 1 writes 0x12345678 to addr 0xFFFF -> response returns the old value 0; a following read returns 0x12345678.
REQ-037 Contention with DMEM_ARB_RR_EN: both requesters continuously valid for 8 transactions -> grants alternate 0,1,0,1..., every transaction takes 2 cycles, 4 per port.
REQ-038 Contention without the macro: the same stimulus -> all 8 grants go to requester 0 and requester 1 is never ready.
REQ-039 Reset mid-ISSUE: rstn low during ISSUE -> mem_en falls immediately, no rsp_valid after release, and the next request completes normally.
REQ-040 Idle: no req_valid for 20 cycles -> mem_en stays 0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NREQ       = 2;
  localparam int unsigned PTR_W      = $clog2(NREQ);
  localparam int unsigned PORT_CORE  = 0;
  localparam int unsigned PORT_LOAD  = 1;
  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Command captured at acceptance and replayed to the RAM in ISSUE.
  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [PTR_W-1:0]      owner;
  } cmd_t;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    onehot_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (oh[i]) onehot_idx = PTR_W'(i);
    end
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// One-hot grant: first valid requester at or after ptr, wrapping around.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port read-first data RAM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [ADDR_W-1:0]     req_addr0,
  input  logic [ADDR_W-1:0]     req_addr1,
  input  logic [DATA_W-1:0]     req_wdata0,
  input  logic [DATA_W-1:0]     req_wdata1,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_di,
  input  logic [DATA_W-1:0]     mem_dout
);

  state_t           state_q;
  cmd_t             cmd_q;
  logic [PTR_W-1:0] ptr;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] win;
  logic             accept;
  logic             win_load;

  dmem_arb_grant u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Accept window covers IDLE and RESP so back-to-back transfers take two cycles.
  assign req_ready = (rstn && (state_q != S_ISSUE)) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign win       = onehot_idx(grant);
  assign win_load  = (win == PTR_W'(PORT_LOAD));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            state_q     <= S_ISSUE;
            cmd_q.we    <= req_we[win];
            cmd_q.addr  <= win_load ? CMD_ADDR_W'(req_addr1) : CMD_ADDR_W'(req_addr0);
            cmd_q.wdata <= win_load ? CMD_DATA_W'(req_wdata1) : CMD_DATA_W'(req_wdata0);
            cmd_q.owner <= win;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: state_q <= S_RESP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Pointer rests just past the last winner so a steady pair alternates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= PTR_W'((32'(win) + 32'd1) % NREQ);
    end
  end
`else
  assign ptr = '0;
`endif

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en & cmd_q.we;
  assign mem_addr  = MEM_ADDR_W'(cmd_q.addr);
  assign mem_di    = DATA_W'(cmd_q.wdata);
  assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << cmd_q.owner) : '0;
  assign rsp_rdata = (state_q == S_RESP) ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural read-first RAM plus a timeline reference model.
// Expected arbitration follows DMEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        rstn       = 1'b1;
  logic [1:0]  req_valid  = '0;
  logic [1:0]  req_we     = '0;
  logic [15:0] req_addr0  = '0;
  logic [15:0] req_addr1  = '0;
  logic [31:0] req_wdata0 = '0;
  logic [31:0] req_wdata1 = '0;
  logic [31:0] mem_dout   = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram [0:65535] = '{default: 32'h0};
  logic [31:0] mdl [0:65535] = '{default: 32'h0};
  logic        pre_en   = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  typedef struct { bit v; bit we; logic [15:0] addr; logic [31:0] wd; } rq_t;
  typedef struct { bit v; int owner; bit we; logic [15:0] addr; logic [31:0] wd; logic [31:0] old; } tx_t;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM with a preload side door.
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      mem_dout <= ram[mem_addr[15:0]];
      if (mem_we) ram[mem_addr[15:0]] <= mem_di;
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v; req_we = we; req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, 16'h1234, 16'h5678, 32'hA5A5A5A5, 32'h5A5A5A5A);
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_mem_en_we got=%b exp=00", {mem_en, mem_we}); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_di !== 32'h0) begin failures++; $display("FAIL reset_mem_di got=%h exp=0", mem_di); end
    drive(2'b01, 2'b00, 16'h0040, 16'h0041, 32'h0, 32'h0);
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL first_grant got=%b exp=01", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL first_issue got en=%b addr=%h exp en=1 addr=40", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL first_rsp got v=%b d=%h exp v=01 d=0", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_read();
    pre_en = 1'b1; pre_addr = 16'h0005; pre_data = 32'hDEADBEEF; mdl[5] = 32'hDEADBEEF;
    @(posedge clk); #1 pre_en = 1'b0;
    idle_cycles(2);
    drive(2'b01, 2'b00, 16'h0005, 16'h0000, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || mem_en !== 1'b0) begin failures++; $display("FAIL read_accept got rdy=%b en=%b exp rdy=01 en=0", req_ready, mem_en); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 32'h5 || rsp_valid !== 2'b00) begin
      failures++; $display("FAIL read_issue got en=%b we=%b addr=%h rsp=%b exp en=1 we=0 addr=5 rsp=00", mem_en, mem_we, mem_addr, rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || mem_en !== 1'b0) begin
      failures++; $display("FAIL read_rsp got v=%b d=%h en=%b exp v=01 d=deadbeef en=0", rsp_valid, rsp_rdata, mem_en); end
  endtask

  task automatic test_write_read();
    idle_cycles(3);
    drive(2'b10, 2'b10, 16'h0000, 16'hFFFF, 32'h0, 32'h12345678);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL wr_accept got=%b exp=10", req_ready); end
    @(posedge clk); #1 drive(2'b10, 2'b00, 16'h0000, 16'hFFFF, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h0000FFFF || mem_di !== 32'h12345678) begin
      failures++; $display("FAIL wr_issue got en=%b we=%b addr=%h di=%h exp 1 1 0000ffff 12345678", mem_en, mem_we, mem_addr, mem_di); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL wr_issue_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rsp_old got v=%b d=%h exp v=10 d=0", rsp_valid, rsp_rdata); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL b2b_accept got=%b exp=10", req_ready); end
    mdl[16'hFFFF] = 32'h12345678;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we} !== 2'b10) begin failures++; $display("FAIL rd_after_wr_issue got=%b exp=10", {mem_en, mem_we}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_after_wr got v=%b d=%h exp v=10 d=12345678", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    int n0;
    int n1;
    n0 = 0; n1 = 0; prev_g = '0;
    pulse_reset();
    idle_cycles(2);
    drive(2'b11, 2'b00, 16'h0100, 16'h0200, 32'h0, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c % 2 == 1) exp_g = (RR && (((c - 1) / 2) % 2 == 1)) ? 2'b10 : 2'b01;
      else exp_g = 2'b00;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL contend_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_g); end
      if (req_ready === 2'b01) n0++;
      if (req_ready === 2'b10) n1++;
      if (c >= 3 && c % 2 == 1) begin
        checks++; if (rsp_valid !== prev_g) begin failures++; $display("FAIL contend_rsp cyc=%0d got=%b exp=%b", c, rsp_valid, prev_g); end
      end
      if (exp_g != 2'b00) prev_g = exp_g;
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== prev_g) begin failures++; $display("FAIL contend_last_rsp got=%b exp=%b", rsp_valid, prev_g); end
    checks++; if (n0 != (RR ? 4 : 8) || n1 != (RR ? 4 : 0)) begin
      failures++; $display("FAIL contend_counts got p0=%0d p1=%0d exp p0=%0d p1=%0d", n0, n1, RR ? 4 : 8, RR ? 4 : 0); end
  endtask

  task automatic test_reset_mid();
    idle_cycles(3);
    drive(2'b01, 2'b00, 16'h0005, 16'h0000, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_accept got=%b exp=01", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL mid_in_issue got=%b exp=1", mem_en); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({mem_en, mem_we, rsp_valid} !== 4'b0) begin failures++; $display("FAIL mid_drop got=%b exp=0000", {mem_en, mem_we, rsp_valid}); end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({mem_en, rsp_valid} !== 3'b0) begin failures++; $display("FAIL mid_no_rsp cyc=%0d got=%b exp=000", i, {mem_en, rsp_valid}); end
    end
    @(posedge clk); #1 drive(2'b10, 2'b00, 16'h0000, 16'h0005, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL mid_next_accept got=%b exp=10", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_next_rsp got v=%b d=%h exp v=10 d=deadbeef", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_idle();
    idle_cycles(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if ({mem_en, mem_we, req_ready, rsp_valid} !== 6'b0) begin
        failures++; $display("FAIL idle cyc=%0d got=%b exp=000000", i, {mem_en, mem_we, req_ready, rsp_valid}); end
    end
    @(posedge clk); #1 drive(2'b10, 2'b00, 16'h0000, 16'h0300, 32'h0, 32'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL idle_then_grant got=%b exp=10", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL idle_then_issue got en=%b addr=%h exp en=1 addr=300", mem_en, mem_addr); end
  endtask

  task automatic test_random();
    rq_t        pend [2];
    tx_t        t1;
    tx_t        t2;
    tx_t        tn;
    int         prefer;
    int         w;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    pulse_reset();
    idle_cycles(2);
    prefer = 0;
    t1 = '{v: 1'b0, owner: 0, we: 1'b0, addr: '0, wd: '0, old: '0};
    t2 = t1;
    for (int p = 0; p < 2; p++) pend[p] = '{v: 1'b0, we: 1'b0, addr: '0, wd: '0};
    for (int c = 0; c < 400; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].v && $urandom_range(0, 99) < 55) begin
          pend[p].v    = 1'b1;
          pend[p].we   = 1'($urandom_range(0, 1));
          pend[p].addr = 16'h0020 + 16'($urandom_range(0, 7));
          pend[p].wd   = 32'($urandom);
        end
      end
      drive({pend[1].v, pend[0].v}, {pend[1].we, pend[0].we}, pend[0].addr, pend[1].addr, pend[0].wd, pend[1].wd);
      @(negedge clk);
      // Accepted at N: RAM busy at N+1, response at N+2; nothing else may start at N+1.
      w = -1;
      if (!t1.v && (pend[0].v || pend[1].v)) begin
        if (pend[0].v && pend[1].v) w = RR ? prefer : 0;
        else w = pend[1].v ? 1 : 0;
      end
      exp_rdy = (w >= 0) ? 2'(32'd1 << w) : 2'b00;
      exp_rsp = t2.v ? 2'(32'd1 << t2.owner) : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if ({mem_en, mem_we} !== {t1.v, t1.v & t1.we}) begin failures++; $display("FAIL rnd_en_we cyc=%0d got=%b exp=%b", c, {mem_en, mem_we}, {t1.v, t1.v & t1.we}); end
      if (t1.v) begin
        checks++; if (mem_addr !== {16'h0, t1.addr} || mem_di !== t1.wd) begin
          failures++; $display("FAIL rnd_issue cyc=%0d got addr=%h di=%h exp addr=%h di=%h", c, mem_addr, mem_di, {16'h0, t1.addr}, t1.wd); end
      end
      checks++; if (rsp_valid !== exp_rsp) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (t2.v) begin
        checks++; if (rsp_rdata !== t2.old) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rsp_rdata, t2.old); end
      end
      t2 = t1;
      tn = '{v: 1'b0, owner: 0, we: 1'b0, addr: '0, wd: '0, old: '0};
      if (w >= 0) begin
        tn.v     = 1'b1;
        tn.owner = w;
        tn.we    = pend[w].we;
        tn.addr  = pend[w].addr;
        tn.wd    = pend[w].wd;
        tn.old   = mdl[pend[w].addr];
        if (pend[w].we) mdl[pend[w].addr] = pend[w].wd;
        pend[w].v = 1'b0;
        prefer    = 1 - w;
      end
      t1 = tn;
    end
    idle_cycles(3);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
